// File: rtl/fp_div_sqrt_unit.sv
// fp_div_sqrt_unit: binary32 divide and square root, both computed every cycle
// from the current operands, with an optional one-cycle output register.
// Round-to-nearest-even, denormal inputs read as zero, tiny results flush to zero.
module fp_div_sqrt_unit #(
  parameter bit OUT_REG = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_a_tdata,
  input  logic [31:0] s_axis_b_tdata,
  output logic [31:0] m_axis_fdiv_tdata,
  output logic [31:0] m_axis_fsqrt_tdata
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;

  assign {sign_a, exp_a, frac_a} = s_axis_a_tdata;
  assign {sign_b, exp_b, frac_b} = s_axis_b_tdata;

  // exp==0 covers both true zero and denormals, which are read as zero
  assign a_zero = (exp_a == 8'd0);
  assign a_inf  = (exp_a == 8'hFF) && (frac_a == '0);
  assign a_nan  = (exp_a == 8'hFF) && (frac_a != '0);
  assign b_zero = (exp_b == 8'd0);
  assign b_inf  = (exp_b == 8'hFF) && (frac_b == '0);
  assign b_nan  = (exp_b == 8'hFF) && (frac_b != '0);

  // ---------------------------------------------------------------- divide
  logic [25:0]       div_q;
  logic [24:0]       div_rem;
  logic [23:0]       div_sig;
  logic              div_guard;
  logic              div_sticky;
  logic [24:0]       div_rnd;
  logic [22:0]       div_frac;
  logic signed [9:0] div_exp;
  logic              div_sign;
  logic [31:0]       fdiv_c;

  assign div_sign = sign_a ^ sign_b;

  // Restoring long division 1.fa / 1.fb; the ratio lies in (0.5, 2), so the
  // first quotient bit has weight 1 and 26 bits give 24 + guard + spare.
  always_comb begin
    div_q   = '0;
    div_rem = {1'b0, 1'b1, frac_a};
    for (int i = 25; i >= 0; i--) begin
      if (div_rem >= {1'b0, 1'b1, frac_b}) begin
        div_q[i] = 1'b1;
        div_rem  = div_rem - {1'b0, 1'b1, frac_b};
      end
      div_rem = div_rem << 1;
    end
  end

  // Normalise the quotient, round to nearest even, fix up exponent on carry-out.
  always_comb begin
    if (div_q[25]) begin
      div_sig    = div_q[25:2];
      div_guard  = div_q[1];
      div_sticky = div_q[0] | (|div_rem);
      div_exp    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
    end else begin
      div_sig    = div_q[24:1];
      div_guard  = div_q[0];
      div_sticky = |div_rem;
      div_exp    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd126;
    end
    div_rnd  = {1'b0, div_sig} + {24'd0, div_guard & (div_sticky | div_sig[0])};
    div_frac = div_rnd[24] ? div_rnd[23:1] : div_rnd[22:0];
    if (div_rnd[24]) begin
      div_exp = div_exp + 10'sd1;
    end
  end

  // Special operands take priority over the computed quotient, then range checks.
  always_comb begin
    fdiv_c = {div_sign, div_exp[7:0], div_frac};
    if (a_nan || b_nan) begin
      fdiv_c = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      fdiv_c = QNAN;
    end else if (b_zero || a_inf) begin
      fdiv_c = {div_sign, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      fdiv_c = {div_sign, 31'd0};
    end else if (div_exp >= 10'sd255) begin
      fdiv_c = {div_sign, 8'hFF, 23'd0};
    end else if (div_exp <= 10'sd0) begin
      fdiv_c = {div_sign, 31'd0};
    end
  end

  // ----------------------------------------------------------- square root
  logic [49:0] sq_rad;
  logic [27:0] sq_rem;
  logic [27:0] sq_trial;
  logic [24:0] sq_root;
  logic [24:0] sq_rnd;
  logic [22:0] sq_frac;
  logic [7:0]  sq_exp;
  logic [31:0] fsqrt_c;

  // Digit-by-digit integer root of the significand scaled so the unbiased
  // exponent becomes even (odd exponent -> one extra left shift); 25 root bits.
  always_comb begin
    sq_rad   = exp_a[0] ? {1'b0, 1'b1, frac_a, 25'd0} : {1'b1, frac_a, 26'd0};
    sq_rem   = '0;
    sq_root  = '0;
    sq_trial = '0;
    for (int i = 24; i >= 0; i--) begin
      sq_rem   = {sq_rem[25:0], sq_rad[2*i +: 2]};
      sq_trial = {1'b0, sq_root, 2'b01};
      if (sq_rem >= sq_trial) begin
        sq_rem  = sq_rem - sq_trial;
        sq_root = {sq_root[23:0], 1'b1};
      end else begin
        sq_root = {sq_root[23:0], 1'b0};
      end
    end
  end

  // Round the root; exponent is floor((eA-127)/2)+127 == (eA+127)>>1.
  always_comb begin
    sq_rnd  = {1'b0, sq_root[24:1]} + {24'd0, sq_root[0] & ((|sq_rem) | sq_root[1])};
    sq_frac = sq_rnd[24] ? sq_rnd[23:1] : sq_rnd[22:0];
    sq_exp  = 8'(({1'b0, exp_a} + 9'd127) >> 1) + {7'd0, sq_rnd[24]};
  end

  // Square-root specials; a negative denormal reads as -0 and returns -0.
  always_comb begin
    fsqrt_c = {1'b0, sq_exp, sq_frac};
    if (a_nan) begin
      fsqrt_c = QNAN;
    end else if (a_zero) begin
      fsqrt_c = {sign_a, 31'd0};
    end else if (sign_a) begin
      fsqrt_c = QNAN;
    end else if (a_inf) begin
      fsqrt_c = 32'h7F80_0000;
    end
  end

  // ---------------------------------------------------------------- output
  generate
    if (OUT_REG) begin : g_out_reg
      // Registered outputs; reset clears them immediately.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_axis_fdiv_tdata  <= '0;
          m_axis_fsqrt_tdata <= '0;
        end else begin
          m_axis_fdiv_tdata  <= fdiv_c;
          m_axis_fsqrt_tdata <= fsqrt_c;
        end
      end
    end else begin : g_out_comb
      logic unused_clk_reset;
      assign unused_clk_reset   = clk | reset;
      assign m_axis_fdiv_tdata  = fdiv_c;
      assign m_axis_fsqrt_tdata = fsqrt_c;
    end
  endgenerate

endmodule

// File: tb/tb_fp_div_sqrt_unit.sv
// tb_fp_div_sqrt_unit: scoreboard bench for fp_div_sqrt_unit in both the
// combinational and the registered build, against an exact-arithmetic model.
module tb_fp_div_sqrt_unit;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int N_RANDOM = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] c_div, c_sqrt, r_div, r_sqrt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ediv;
    logic [31:0] esqrt;
  } sb_t;

  sb_t sb[$];

  fp_div_sqrt_unit #(.OUT_REG(1'b0)) dut_c (
    .clk(clk), .reset(reset),
    .s_axis_a_tdata(a_in), .s_axis_b_tdata(b_in),
    .m_axis_fdiv_tdata(c_div), .m_axis_fsqrt_tdata(c_sqrt)
  );

  fp_div_sqrt_unit #(.OUT_REG(1'b1)) dut_r (
    .clk(clk), .reset(reset),
    .s_axis_a_tdata(a_in), .s_axis_b_tdata(b_in),
    .m_axis_fdiv_tdata(r_div), .m_axis_fsqrt_tdata(r_sqrt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h want=%08h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // Round an exact value (v + fraction) * 2^p to binary32 RNE with flush-to-zero.
  function automatic logic [31:0] round_pack(input logic s, input logic [63:0] v_in,
                                             input int p_in, input logic st_in);
    logic [63:0] v, sig;
    int p, be;
    logic st, g;
    v = v_in; p = p_in; st = st_in;
    while (v >= 64'h200_0000) begin
      st = st | v[0];
      v = v >> 1;
      p++;
    end
    g = v[0];
    sig = v >> 1;
    p++;
    if (g && (st || sig[0])) sig++;
    if (sig == 64'h100_0000) begin
      sig = sig >> 1;
      p++;
    end
    be = p + 150;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0) return {s, 31'd0};
    return {s, be[7:0], sig[22:0]};
  endfunction

  function automatic logic [63:0] isqrt64(input logic [63:0] n);
    logic [63:0] lo, hi, mid;
    lo = 0; hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb;
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, s;
    logic [63:0] ma, mb, n;
    ea = a[30:23]; eb = b[30:23];
    nan_a = (ea == 8'hFF) && (a[22:0] != 0);
    nan_b = (eb == 8'hFF) && (b[22:0] != 0);
    inf_a = (ea == 8'hFF) && (a[22:0] == 0);
    inf_b = (eb == 8'hFF) && (b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    s = a[31] ^ b[31];
    if (nan_a || nan_b) return QNAN;
    if ((zero_a && zero_b) || (inf_a && inf_b)) return QNAN;
    if (zero_b || inf_a) return {s, 8'hFF, 23'd0};
    if (inf_b || zero_a) return {s, 31'd0};
    ma = {40'd1, a[22:0]};
    mb = {40'd1, b[22:0]};
    n = ma << 38;
    return round_pack(s, n / mb, int'(ea) - int'(eb) - 38, (n % mb) != 0);
  endfunction

  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    logic [7:0] ea;
    logic [63:0] m, n, v;
    int t, sh;
    ea = a[30:23];
    if (ea == 8'hFF && a[22:0] != 0) return QNAN;
    if (ea == 0) return {a[31], 31'd0};
    if (a[31]) return QNAN;
    if (ea == 8'hFF) return 32'h7F80_0000;
    m = {40'd1, a[22:0]};
    t = int'(ea) - 150;
    sh = (((t - 38) % 2) == 0) ? 38 : 39;
    n = m << sh;
    v = isqrt64(n);
    return round_pack(1'b0, v, (t - sh) / 2, (v * v) != n);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    if ($urandom_range(0, 9) == 0) return $urandom;
    r = $urandom;
    r[30:23] = 8'($urandom_range(1, 254));
    r[31] = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  // ----------------------------------------------------------------- driver
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ediv, input logic [31:0] esqrt);
    sb_t e;
    @(negedge clk);
    a_in = a;
    b_in = b;
    e.a = a; e.b = b; e.ediv = ediv; e.esqrt = esqrt;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------- monitor
  // After each rising edge both builds present the operands applied before it.
  initial begin : monitor
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("comb_div a=%08h b=%08h", e.a, e.b), c_div, e.ediv);
        check($sformatf("comb_sqrt a=%08h", e.a), c_sqrt, e.esqrt);
        check($sformatf("reg_div a=%08h b=%08h", e.a, e.b), r_div, e.ediv);
        check($sformatf("reg_sqrt a=%08h", e.a), r_sqrt, e.esqrt);
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stimulus
    logic [31:0] ra, rb;
    int waited;

    @(posedge clk);
    #1;
    check("reset_div", r_div, 32'h0);
    check("reset_sqrt", r_sqrt, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    drive(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, ref_sqrt(32'h40C0_0000));
    drive(32'h4080_0000, 32'h3F80_0000, 32'h4080_0000, 32'h4000_0000);
    drive(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 32'h3F80_0000);
    drive(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3FB5_04F3);
    drive(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    drive(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000);
    drive(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, QNAN);
    drive(32'h0000_0000, 32'h0000_0000, QNAN, 32'h0000_0000);
    drive(32'h7F80_0000, 32'h7F80_0000, QNAN, 32'h7F80_0000);
    drive(32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000);
    drive(32'hC080_0000, 32'h3F80_0000, 32'hC080_0000, QNAN);
    drive(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h8000_0000);
    drive(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, ref_sqrt(32'h7F7F_FFFF));
    drive(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 32'h2000_0000);
    drive(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000);
    drive(32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 32'h8000_0000);
    drive(32'h7FC1_2345, 32'h3F80_0000, QNAN, QNAN);
    drive(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, QNAN);

    for (int i = 0; i < N_RANDOM; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      drive(ra, rb, ref_div(ra, rb), ref_sqrt(ra));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end

    // Registered build: latency, async reset, and release behaviour.
    @(negedge clk);
    a_in = 32'h3F80_0000;
    b_in = 32'h3F80_0000;
    @(negedge clk);
    a_in = 32'h40C0_0000;
    b_in = 32'h4040_0000;
    #3;
    check("reg_before_edge", r_div, 32'h3F80_0000);
    @(posedge clk);
    #1;
    check("reg_after_edge", r_div, 32'h4000_0000);
    check("reg_after_edge_sqrt", r_sqrt, ref_sqrt(32'h40C0_0000));

    @(negedge clk);
    a_in = 32'h3F80_0000;
    b_in = 32'h4040_0000;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_div", r_div, 32'h0);
    check("reset_async_sqrt", r_sqrt, 32'h0);
    a_in = 32'h40C0_0000;
    @(posedge clk);
    #1;
    check("reset_held_div", r_div, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_before_edge", r_div, 32'h0);
    @(posedge clk);
    #1;
    check("release_edge_div", r_div, 32'h4000_0000);
    check("release_edge_sqrt", r_sqrt, ref_sqrt(32'h40C0_0000));

    // Unknown divisor must not disturb the square root.
    @(negedge clk);
    a_in = 32'h4080_0000;
    b_in = 'x;
    #1;
    check("sqrt_b_unknown", c_sqrt, 32'h4000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
